md_scheduler: RTL
=================

Name: md_scheduler

Overview:
- Sequences the multiply/divide resource for the P6 pipeline; sits in E stage beside the ALU.
- Accepts an MD operation from E, runs it for a fixed latency, owns HI/LO and drives the MD stall request to the hazard unit.
- mfhi/mflo read the hi/lo outputs directly; the E-stage decoder supplies start and md_op.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- start  input  1  E-stage instruction is an MD op; sampled on rising edge
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved
- rs_data  input  32  forwarded rs operand (dividend/multiplicand/mt source)
- rt_data  input  32  forwarded rt operand (divisor/multiplier)
- d_uses_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  operation in flight
- stall  output  1  stall request to hazard unit
- hi  output  32  HI register
- lo  output  32  LO register
- op_dropped  output  1  one-cycle pulse: start ignored (busy or reserved op)

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, hi=lo=0, pending result 0, busy=0, op_dropped=0. Reset mid-operation aborts it; HI/LO are not written.
- States: IDLE, RUN.
- IDLE, start=1, md_op 0-3: latch result into pending_hi/pending_lo at edge t; counter <= MULT_CYCLES or DIV_CYCLES; go RUN. HI/LO unchanged at edge t.
- RUN: counter decrements each edge; on the edge where counter==1, hi/lo <= pending, counter <= 0, state <= IDLE.
- Result: busy=1 for exactly N cycles after edge t; new hi/lo visible after edge t+N; busy=0 in that same cycle.
- IDLE, start=1, md_op 4/5: hi (MTHI) or lo (MTLO) <= rs_data at the same edge; no busy.
- start=1 with reserved op (6/7), or any start while RUN: ignored, op_dropped=1 for one cycle, state unchanged. The hazard unit must prevent this; it is a protocol error.
- busy: registered, equals (state==RUN).
- stall: combinational, d_uses_md & (busy | (start & md_op<=3)). Covers the cycle where the op is still in E, before busy rises.
- MULT: signed 32x32 -> 64, hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: signed, quotient truncated toward zero -> lo; remainder with dividend sign -> hi.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned.
- Divide by zero (rt_data==0): the op still runs DIV_CYCLES, then pending = current hi/lo, so HI/LO are unchanged.
- Result is computed combinationally at start and held; only write timing is sequenced.

Test Plan:
- Reset held low mid-RUN (after 3 cycles of DIV) -> busy=0 immediately; hi=lo=0; after release the next start is accepted.
- MULT rs=0xFFFFFFFE, rt=3 at edge t -> busy=1 edges t..t+4; after t+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 with hi=0x11, lo=0x22 beforehand -> HI/LO unchanged after 10 cycles.
- start=1 MULT with d_uses_md=1 in the same cycle -> stall=1 that cycle and all 5 busy cycles; stall=0 in the cycle busy falls. With d_uses_md=0 -> stall=0 throughout.
- MTLO rs=0x1234 in IDLE -> lo=0x1234 after that edge, busy stays 0. MTHI issued while RUN -> ignored, op_dropped pulses, hi unchanged.
- Back-to-back: DIV completes, MULT started in the cycle busy falls -> accepted, busy high for 5 more cycles, final hi/lo from MULT.

Source files
------------

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, holds the
// precomputed result for a fixed latency and raises the MD stall.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        op_dropped
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi_n, lo_n;
  logic [31:0]   phi, plo, phi_n, plo_n;
  logic          drop_n;

  logic [63:0]   prod_s, prod_u;
  logic          a_neg, b_neg, div_zero;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag;
  logic [31:0]   q_s, r_s, q_u, r_u;
  logic [31:0]   res_hi, res_lo;
  logic          op_mult, op_multu, op_div, op_divu;

  assign op_mult  = (md_op == 3'd0);
  assign op_multu = (md_op == 3'd1);
  assign op_div   = (md_op == 3'd2);
  assign op_divu  = (md_op == 3'd3);

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data})
                * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case
  assign a_neg    = rs_data[31];
  assign b_neg    = rt_data[31];
  assign a_mag    = a_neg ? -rs_data : rs_data;
  assign b_mag    = b_neg ? -rt_data : rt_data;
  assign div_zero = (rt_data == 32'd0);
  assign q_mag    = div_zero ? 32'd0 : a_mag / b_mag;
  assign r_mag    = div_zero ? 32'd0 : a_mag % b_mag;
  assign q_s      = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r_s      = a_neg ? -r_mag : r_mag;
  assign q_u      = div_zero ? 32'd0 : rs_data / rt_data;
  assign r_u      = div_zero ? 32'd0 : rs_data % rt_data;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    unique case (1'b1)
      op_mult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      op_multu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      op_div: if (!div_zero) begin
        res_hi = r_s;
        res_lo = q_s;
      end
      op_divu: if (!div_zero) begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    phi_n   = phi;
    plo_n   = plo;
    drop_n  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        if (!md_op[2]) begin
          phi_n   = res_hi;
          plo_n   = res_lo;
          cnt_n   = md_op[1] ? CW'(DIV_CYCLES)
                             : CW'(MULT_CYCLES);
          state_n = RUN;
        end else if (md_op == 3'd4) begin
          hi_n = rs_data;
        end else if (md_op == 3'd5) begin
          lo_n = rs_data;
        end else begin
          drop_n = 1'b1;
        end
      end
      RUN: begin
        drop_n = start;
        if (cnt == CW'(1)) begin
          hi_n    = phi;
          lo_n    = plo;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      phi        <= '0;
      plo        <= '0;
      op_dropped <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi         <= hi_n;
      lo         <= lo_n;
      phi        <= phi_n;
      plo        <= plo_n;
      op_dropped <= drop_n;
    end
  end

  assign busy  = (state == RUN);
  assign stall = d_uses_md
               & (busy | (start & ~md_op[2]));

endmodule
